// File: rtl/sixteen_four_encoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface   : sixteen_four_encoder_if                                |
// | Description : Button-in / code-out bundle for sixteen_four_encoder.  |
// |               btn   [15:0] raw button lines (bit i = position i)     |
// |               mode  [1:0]  encoding policy                           |
// |               ready        consumer accepts code                     |
// |               code  [3:0]  encoded position index                    |
// |               valid        code is held until accepted               |
// |               multi        more than one button at capture           |
// |               err          one-cycle reject pulse (mode 3)           |
// |               master = encoder side, slave = game controller side.   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface sixteen_four_encoder_if;
   logic [15:0] btn;
   logic [1:0]  mode;
   logic        ready;
   logic [3:0]  code;
   logic        valid;
   logic        multi;
   logic        err;

   modport master (
      input  btn, mode, ready,
      output code, valid, multi, err
   );

   modport slave (
      output btn, mode, ready,
      input  code, valid, multi, err
   );
endinterface
`default_nettype wire

// File: rtl/sixteen_four_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sixteen_four_encoder                                   |
// | Description : Synchronises and debounces 16 button lines, then       |
// |               priority-encodes one press into a 4-bit index offered  |
// |               on a valid/ready handshake.                            |
// |   clk    in   system clock, rising edge                              |
// |   rst_n  in   asynchronous active-low reset                          |
// |   bus    master modport: btn/mode/ready in, code/valid/multi/err out |
// |   mode: 0 disabled, 1 lowest index, 2 highest index, 3 single only   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module sixteen_four_encoder #(
   parameter int DEB_CYCLES = 4,
   parameter int CNT_W      = $clog2(DEB_CYCLES + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   sixteen_four_encoder_if.master bus
);

   localparam logic [CNT_W-1:0] c_deb_max  = CNT_W'(DEB_CYCLES);
   localparam logic [CNT_W-1:0] c_deb_load = CNT_W'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      WAIT_REL = 2'd0,
      ARMED    = 2'd1,
      HOLD     = 2'd2
   } state_t;

   logic [15:0]      r_s1;
   logic [15:0]      r_s2;
   logic [15:0]      r_deb;
   logic [CNT_W-1:0] r_cnt;

   state_t           r_state;
   logic [3:0]       r_code;
   logic             r_valid;
   logic             r_multi;
   logic             r_err;

   logic [3:0]       w_lo_idx;
   logic [3:0]       w_hi_idx;
   logic             w_multi;
   logic             w_deb_zero;
   logic             w_settled;

   // ------------------------------------------------------------------
   // Synchroniser and whole-vector debounce. Comparing s1 against s2
   // flags the edge on which s2 is about to change, so the counter
   // restarts on the same edge s2 takes a new value. A change held
   // stable lands in deb DEB_CYCLES+2 edges after it is first sampled.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1  <= '0;
         r_s2  <= '0;
         r_cnt <= '0;
         r_deb <= '0;
      end else begin
         r_s1 <= bus.btn;
         r_s2 <= r_s1;
         if (r_s1 != r_s2) begin
            r_cnt <= '0;
         end else begin
            if (r_cnt != c_deb_max)
               r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_deb_load)
               r_deb <= r_s2;
         end
      end
   end

   // ------------------------------------------------------------------
   // Encoding helpers from the debounced vector.
   // ------------------------------------------------------------------
   always_comb begin
      w_lo_idx = 4'd0;
      w_hi_idx = 4'd0;
      for (int i = 15; i >= 0; i--)
         if (r_deb[i]) w_lo_idx = 4'(i);
      for (int i = 0; i < 16; i++)
         if (r_deb[i]) w_hi_idx = 4'(i);
   end

   // More than one bit set: clearing the lowest set bit leaves something.
   assign w_multi    = (r_deb & (r_deb - 16'd1)) != 16'd0;
   assign w_deb_zero = (r_deb == 16'd0);
   // A saturated counter means deb reflects a genuinely stable input and
   // not merely its reset value; this keeps a button held through reset
   // from being mistaken for a release.
   assign w_settled  = (r_cnt == c_deb_max);

   // ------------------------------------------------------------------
   // Capture / handshake FSM with registered outputs.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= WAIT_REL;
         r_code  <= 4'd0;
         r_valid <= 1'b0;
         r_multi <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_err <= 1'b0;
         if (bus.mode == 2'd0) begin
            // Disabled: drop any pending event and wait for a release.
            r_state <= WAIT_REL;
            r_valid <= 1'b0;
         end else begin
            case (r_state)
               WAIT_REL: begin
                  if (w_deb_zero && w_settled)
                     r_state <= ARMED;
               end
               ARMED: begin
                  if (!w_deb_zero) begin
                     if (bus.mode == 2'd3 && w_multi) begin
                        r_err   <= 1'b1;
                        r_state <= WAIT_REL;
                     end else begin
                        // Mode 3 reaches here only with a single bit set,
                        // so the lowest index is the pressed index.
                        r_code  <= (bus.mode == 2'd2) ? w_hi_idx : w_lo_idx;
                        r_multi <= w_multi;
                        r_valid <= 1'b1;
                        r_state <= HOLD;
                     end
                  end
               end
               HOLD: begin
                  // valid is always 1 here, so ready alone completes it.
                  if (bus.ready) begin
                     r_valid <= 1'b0;
                     r_state <= WAIT_REL;
                  end
               end
               default: begin
                  r_state <= WAIT_REL;
                  r_valid <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.code  = r_code;
   assign bus.valid = r_valid;
   assign bus.multi = r_multi;
   assign bus.err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sixteen_four_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_sixteen_four_encoder                                |
// | Description : Self-checking bench for sixteen_four_encoder with a    |
// |               history-window reference model and random stimulus.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_sixteen_four_encoder;

   localparam int DEB = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   sixteen_four_encoder_if bus ();

   sixteen_four_encoder #(.DEB_CYCLES(DEB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model. The debounced value is whatever the last DEB+1
   // samples agreed on; a release counts once DEB+1 consecutive zero
   // samples have been seen (reset seeds two zero samples, the cleared
   // synchroniser contents).
   // ------------------------------------------------------------------
   logic [15:0] hist[$];
   logic [15:0] m_deb    = '0;
   bit          m_stable = 1'b0;
   int          m_phase  = 0;      // 0 waiting release, 1 armed, 2 holding
   logic [3:0]  m_code   = '0;
   logic        m_valid  = 1'b0;
   logic        m_multi  = 1'b0;
   logic        m_err    = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist     = '{16'h0, 16'h0};
         m_deb    = '0;
         m_stable = 1'b0;
         m_phase  = 0;
         m_code   = '0;
         m_valid  = 1'b0;
         m_multi  = 1'b0;
         m_err    = 1'b0;
      end else begin
         automatic logic [15:0] d  = m_deb;
         automatic int          pc = $countones(d);
         automatic bit          st;
         m_err = 1'b0;
         if (bus.mode == 2'd0) begin
            m_phase = 0;
            m_valid = 1'b0;
         end else if (m_phase == 0) begin
            if (d == 16'h0 && m_stable) m_phase = 1;
         end else if (m_phase == 1) begin
            if (d != 16'h0) begin
               if (bus.mode == 2'd3 && pc > 1) begin
                  m_err   = 1'b1;
                  m_phase = 0;
               end else begin
                  if (bus.mode == 2'd2)
                     m_code = 4'($clog2(int'(d) + 1) - 1);
                  else
                     m_code = 4'($clog2(int'(d & (~d + 16'd1))));
                  m_multi = (pc > 1);
                  m_valid = 1'b1;
                  m_phase = 2;
               end
            end
         end else if (bus.ready) begin
            m_valid = 1'b0;
            m_phase = 0;
         end
         // Debounce window update.
         st = (hist.size() >= DEB + 1);
         if (st)
            for (int k = 1; k <= DEB + 1; k++)
               if (hist[hist.size() - k] != hist[hist.size() - 1]) st = 1'b0;
         if (st) m_deb = hist[hist.size() - 1];
         m_stable = st;
         hist.push_back(bus.btn);
         if (hist.size() > 8) void'(hist.pop_front());
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("valid", 32'(bus.valid), 32'(m_valid));
         chk("err",   32'(bus.err),   32'(m_err));
         chk("code",  32'(bus.code),  32'(m_code));
         chk("multi", 32'(bus.multi), 32'(m_multi));
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic accept();
      bus.ready = 1'b1;
      step(1);
      bus.ready = 1'b0;
   endtask

   task automatic release_btn();
      bus.btn = 16'h0;
      step(12);
   endtask

   int vcount;
   int ecount;

   initial begin
      bus.btn   = 16'h0;
      bus.mode  = 2'd1;
      bus.ready = 1'b0;
      #1 rst_n = 1'b0;
      #1 chk("reset valid", 32'(bus.valid), 32'd0);
      chk("reset code", 32'(bus.code), 32'd0);
      chk("reset err",  32'(bus.err),  32'd0);
      step(2);
      rst_n = 1'b1;
      step(20);

      // Single press, latency, hold, accept, no repeat while held.
      bus.btn = 16'h0020;
      step(6);
      chk("lat6 valid", 32'(bus.valid), 32'd0);
      step(1);
      chk("lat7 valid", 32'(bus.valid), 32'd1);
      chk("lat7 code",  32'(bus.code),  32'd5);
      chk("lat7 multi", 32'(bus.multi), 32'd0);
      step(20);
      chk("hold code",  32'(bus.code),  32'd5);
      chk("hold valid", 32'(bus.valid), 32'd1);
      accept();
      chk("accepted valid", 32'(bus.valid), 32'd0);
      vcount = 0;
      for (int i = 0; i < 30; i++) begin
         step(1);
         if (bus.valid) vcount++;
      end
      chk("held no repeat", 32'(vcount), 32'd0);
      release_btn();

      // Multi-press under each policy.
      bus.btn = 16'h8011;
      step(7);
      chk("m1 code",  32'(bus.code),  32'd0);
      chk("m1 multi", 32'(bus.multi), 32'd1);
      accept();
      release_btn();
      bus.mode = 2'd2;
      bus.btn  = 16'h8011;
      step(7);
      chk("m2 code",  32'(bus.code),  32'd15);
      chk("m2 multi", 32'(bus.multi), 32'd1);
      accept();
      release_btn();
      bus.mode = 2'd3;
      bus.btn  = 16'h8011;
      ecount = 0;
      vcount = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (bus.err)   ecount++;
         if (bus.valid) vcount++;
      end
      chk("m3 err pulses", 32'(ecount), 32'd1);
      chk("m3 no valid",   32'(vcount), 32'd0);
      release_btn();
      bus.mode = 2'd1;

      // Bounce shorter than the debounce window.
      vcount = 0;
      for (int i = 0; i < 3; i++) begin
         bus.btn = 16'h0100;
         step(2);
         if (bus.valid) vcount++;
         bus.btn = 16'h0;
         step(2);
         if (bus.valid) vcount++;
      end
      for (int i = 0; i < 12; i++) begin
         step(1);
         if (bus.valid) vcount++;
      end
      chk("bounce no valid", 32'(vcount), 32'd0);
      bus.btn = 16'h0100;
      step(7);
      chk("bounce then hold code", 32'(bus.code), 32'd8);
      accept();
      release_btn();

      // One-hot sweep.
      vcount = 0;
      for (int i = 0; i < 16; i++) begin
         bus.btn = 16'(1 << i);
         step(7);
         if (bus.valid) vcount++;
         chk("sweep code",  32'(bus.code),  32'(i));
         chk("sweep multi", 32'(bus.multi), 32'd0);
         accept();
         bus.btn = 16'h0;
         step(10);
      end
      chk("sweep valids", 32'(vcount), 32'd16);

      // Asynchronous reset while holding an event.
      bus.btn = 16'h0008;
      step(7);
      chk("pre-reset code", 32'(bus.code), 32'd3);
      rst_n = 1'b0;
      #1;
      chk("async valid", 32'(bus.valid), 32'd0);
      chk("async code",  32'(bus.code),  32'd0);
      step(1);
      rst_n = 1'b1;
      vcount = 0;
      for (int i = 0; i < 30; i++) begin
         step(1);
         if (bus.valid) vcount++;
      end
      chk("post-reset held", 32'(vcount), 32'd0);
      release_btn();
      bus.btn = 16'h0008;
      step(7);
      chk("re-press valid", 32'(bus.valid), 32'd1);
      chk("re-press code",  32'(bus.code),  32'd3);
      accept();
      release_btn();

      // Disable while holding.
      bus.btn = 16'h0200;
      step(7);
      chk("m0 pre code", 32'(bus.code), 32'd9);
      bus.mode = 2'd0;
      step(1);
      chk("m0 valid", 32'(bus.valid), 32'd0);
      bus.mode = 2'd1;
      vcount = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (bus.valid) vcount++;
      end
      chk("m0 held no event", 32'(vcount), 32'd0);
      release_btn();
      bus.btn = 16'h0200;
      step(7);
      chk("m0 re-press code", 32'(bus.code), 32'd9);
      accept();
      release_btn();

      // Randomized segments checked by the model every cycle.
      for (int s = 0; s < 300; s++) begin
         automatic int kind = int'($urandom_range(0, 5));
         automatic int dur  = int'($urandom_range(1, 14));
         if ($urandom_range(0, 9) == 0)
            bus.mode = 2'($urandom_range(0, 3));
         else if (bus.mode == 2'd0)
            bus.mode = 2'($urandom_range(1, 3));
         case (kind)
            0, 5:    bus.btn = 16'h0;
            1, 2:    bus.btn = 16'(1 << $urandom_range(0, 15));
            3:       bus.btn = 16'($urandom);
            default: bus.btn = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
         endcase
         for (int c = 0; c < dur; c++) begin
            bus.ready = ($urandom_range(0, 2) == 0);
            step(1);
         end
      end
      bus.ready = 1'b0;
      step(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sixteen_four_encoder.md
Name: sixteen_four_encoder

Overview:
- Reverse direction of the 4-to-16 LED decoder: takes 16 one-hot-ish raw button/pad lines (one per LED position) and returns the 4-bit index of the pressed position.
- Synchronises and debounces the 16 inputs, priority-encodes one press event, and presents it on a valid/ready handshake to the game controller.
- `mode` selects the encoding policy, mirroring the decoder's `mode` input.
- One event per press: every button must be released before the next capture.

Parameters:
- `DEB_CYCLES`, 4, consecutive stable cycles required before the debounced vector updates (≥2).
- `CNT_W`, `$clog2(DEB_CYCLES+1)`, debounce counter width (derived; not overridden).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `btn`  in  16  raw asynchronous button lines, bit i = LED position i, active-high.
- `mode`  in  2  0 = disabled, 1 = lowest-index priority, 2 = highest-index priority, 3 = single-press only.
- `ready`  in  1  consumer accepts `code` when `valid` && `ready`.
- `code`  out  4  encoded position index.
- `valid`  out  1  `code` is held stable until accepted.
- `multi`  out  1  more than one bit was set at capture; qualified by `valid`.
- `err`  out  1  one-cycle pulse: mode-3 capture rejected because of a multi-press.

Behaviour:
- Reset: async on `rst_n`=0. All of `code`, `valid`, `multi`, `err`, sync flops, debounced vector `deb` and counter clear to 0. FSM goes to WAIT_REL.
- Sync: two flops per bit, `s1` then `s2`.
- Debounce (whole vector):
  - If `s2` != `s2_prev`, the counter clears.
  - Otherwise the counter increments, saturating at `DEB_CYCLES`.
  - When the counter reaches `DEB_CYCLES-1` with `s2` unchanged, `deb` <= `s2`.
  - Net: a raw change held stable is reflected in `deb` DEB_CYCLES+2 edges later.
  - A glitch shorter than `DEB_CYCLES` cycles never reaches `deb`.
- FSM states WAIT_REL, ARMED, HOLD:
  - WAIT_REL -> ARMED when `deb`==0 and `mode`!=0.
  - ARMED -> HOLD when `deb`!=0 and the capture is accepted. On that edge: `code`, `multi` are loaded, `valid` <= 1. Total latency from a stable raw press to `valid` = DEB_CYCLES+3 edges.
  - ARMED -> WAIT_REL when `mode`==3 and `popcount(deb)`>1. On that edge `err` <= 1 for exactly one cycle; no `valid`.
  - HOLD -> WAIT_REL on `valid` && `ready`; `valid` <= 0 on that edge.
- Encoding:
  - Mode 1: index of the lowest set bit.
  - Mode 2: index of the highest set bit.
  - Mode 3: index of the single set bit.
  - `multi` = (`popcount(deb)` > 1); always 0 in mode 3.
- `mode` is sampled only at capture. A `mode` change while in HOLD does not alter `code`.
- `mode`==0 in any state: next state is WAIT_REL, `valid` <= 0, a pending event is discarded, `err` stays 0.
- Presses arriving in HOLD or WAIT_REL are ignored. No queueing; at most one event is outstanding.
- A held button produces exactly one event. Release (`deb`==0) is required before the next one.
- `ready` high before `valid`: no effect. `ready` in the same cycle `valid` rises: no accept that cycle. Accept occurs on the first edge where `valid` is already 1 and `ready`=1.
- `code` and `multi` remain unchanged after accept until the next capture. `valid` is the only qualifier.
- `rst_n` asserted in HOLD: `valid` drops immediately (async). After release, the FSM needs all buttons released before arming.

Test Plan (`DEB_CYCLES`=4):
- mode=1, `btn`=16'h0020 held, `ready`=0 -> `valid`=1, `code`=5, `multi`=0, 7 edges after `btn` change. `code` stays 5 for 20 cycles. `ready`=1 for 1 cycle -> `valid`=0. Keep `btn` held 30 more cycles -> no second `valid`.
- `btn`=16'h8011: mode=1 -> `code`=0, `multi`=1. Release, wait, re-press with mode=2 -> `code`=15, `multi`=1. Re-press with mode=3 -> `err` high exactly 1 cycle, `valid` stays 0.
- Bounce: `btn`=16'h0100 toggled on/off every 2 cycles for 12 cycles, then 0 -> `valid` never asserts. Then hold 16'h0100 -> `code`=8.
- Sweep: for i=0..15, press `btn`=1<<i, accept with `ready`, release -> `code`=i each time, 16 `valid`s total, `multi`=0 throughout.
- Reset mid-HOLD: `valid`=1, `code`=3 (`btn`=16'h0008 held), pulse `rst_n` low 1 cycle -> `valid`/`code` 0 immediately. No new `valid` until the button is released and pressed again.
- mode=0 while HOLD with `code`=9 -> `valid` falls next edge. mode=1 with `btn` still held -> no event until release and re-press.
